// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: status encoding, mm:ss limits and a saturation helper shared by the timer and the stopwatch
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } status_t;

    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [5:0] MAX_MIN = 6'd59;

    function automatic logic [5:0] sat(input logic [5:0] v, input logic [5:0] max);
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// mmss_down_counter: minutes/seconds register pair with load, borrow-aware decrement and zero detect
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr              : synchronous return to 00:00 (highest priority)
//   ld, ld_min/sec   : load a value (already range-limited by the caller)
//   dec              : decrement by one second; ignored at 00:00
//   minutes/seconds  : current count
//   zero, last       : count is 00:00 / count is 00:01
module mmss_down_counter
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  logic [5:0] ld_min,
    input  logic [5:0] ld_sec,
    input  logic       dec,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       zero,
    output logic       last
);

    assign zero = (minutes == 6'd0) && (seconds == 6'd0);
    assign last = (minutes == 6'd0) && (seconds == 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            minutes <= '0;
            seconds <= '0;
        end else if (clr) begin
            minutes <= '0;
            seconds <= '0;
        end else if (ld) begin
            minutes <= ld_min;
            seconds <= ld_sec;
        end else if (dec && !zero) begin
            // borrow a minute when the seconds field is exhausted
            minutes <= (seconds == 6'd0) ? minutes - 6'd1 : minutes;
            seconds <= (seconds == 6'd0) ? MAX_SEC : seconds - 6'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss countdown FSM (IDLE/RUNNING/PAUSED/EXPIRED) with preset, pause and expiry pulse
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick                : one-second decrement strobe while RUNNING
//   load, load_min/sec  : preset strobe and value (values above 59 saturate)
//   start, stop, clear  : control strobes, priority clear > stop > start > load
//   minutes, seconds    : current count
//   status              : current state encoding
//   expired             : one-cycle pulse when the count reaches 00:00
// Build option: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload the preset on expiry and keep running.
module countdown_timer
    import countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] status,
    output logic       expired
);

    status_t    state, next_state;
    logic [5:0] rl_min, rl_sec, pre_min, pre_sec;
    logic       do_stop, do_start, do_load, do_dec, hit_zero, cnt_ld, zero, last;

    always_comb begin
        do_stop    = !clear && stop && (state == RUNNING);
        do_start   = !clear && !do_stop && start && (state == IDLE || state == PAUSED) && !zero;
        do_load    = !clear && !do_stop && !do_start && load && (state != RUNNING);
        // a coinciding stop wins over the tick, so the paused count is not decremented
        do_dec     = !clear && !do_stop && tick && (state == RUNNING);
        hit_zero   = do_dec && last;
        // the preset path doubles as the reload register's next value, so the same
        // mux feeds both the register and the counter's load inputs
        pre_min    = do_load ? sat(load_min, MAX_MIN) : rl_min;
        pre_sec    = do_load ? sat(load_sec, MAX_SEC) : rl_sec;
        next_state = state;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        cnt_ld     = do_load || hit_zero;
`else
        cnt_ld     = do_load;
`endif
        if (clear)
            next_state = IDLE;
        else if (do_stop)
            next_state = PAUSED;
        else if (do_start)
            next_state = RUNNING;
        else if (do_load)
            next_state = IDLE;
`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        else if (hit_zero)
            next_state = EXPIRED;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            expired <= 1'b0;
            rl_min  <= '0;
            rl_sec  <= '0;
        end else begin
            state   <= next_state;
            expired <= hit_zero;
            rl_min  <= pre_min;
            rl_sec  <= pre_sec;
        end
    end

    mmss_down_counter u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clear),
        .ld      (cnt_ld),
        .ld_min  (pre_min),
        .ld_sec  (pre_sec),
        .dec     (do_dec),
        .minutes (minutes),
        .seconds (seconds),
        .zero    (zero),
        .last    (last)
    );

    assign status = state;

endmodule
